// File: rtl/ifetch_prefetch_if.sv
// Fetch front-end bundle: memory request/response channel, redirect, and the
// instruction hand-off to decode. master = fetch unit, slave = memory/decode side.
interface ifetch_prefetch_if #(
  parameter int XLEN = 32
);
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_resp_valid;
  logic [31:0]     mem_resp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst_data;
  logic [XLEN-1:0] inst_pc;

  modport master (
    output mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
           redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
           redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/ifetch_prefetch.sv
// Instruction prefetcher: issues sequential word fetches with bounded credits,
// buffers in-order responses in a FIFO and drops responses made stale by a redirect.
module ifetch_prefetch #(
  parameter int              XLEN            = 32,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input logic              clk,
  input logic              rst,
  ifetch_prefetch_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int SW = CW + 2;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] head_pc_q, head_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]     fifo_q [DEPTH];

  logic            redirect;
  logic [XLEN-1:0] redirect_pc_aligned;
  logic [SW-1:0]   credits_used;
  logic            req_valid;
  logic            req_fire;
  logic            resp_ok;
  logic            resp_from_drop;
  logic            push;
  logic            pop;

  assign redirect            = bus.redirect_valid;
  assign redirect_pc_aligned = bus.redirect_pc & ~XLEN'(3);

  // Every request holds a FIFO slot from issue until its data is popped,
  // stale requests included, so a kept response can never overflow the FIFO.
  assign credits_used = SW'(count_q) + SW'(outst_q) + SW'(drop_q);
  assign req_valid    = !rst && !redirect
                     && (outst_q < CW'(MAX_OUTSTANDING))
                     && (credits_used < SW'(DEPTH));
  assign req_fire     = req_valid && bus.mem_req_ready;

  assign resp_ok        = bus.mem_resp_valid && ((outst_q != '0) || (drop_q != '0));
  assign resp_from_drop = resp_ok && (drop_q != '0);
  assign push           = resp_ok && !resp_from_drop && !redirect;
  assign pop            = (count_q != '0) && bus.inst_ready && !redirect;

  assign bus.mem_req_valid = req_valid;
  assign bus.mem_req_addr  = fetch_pc_q;
  assign bus.inst_valid    = (count_q != '0);
  assign bus.inst_data     = fifo_q[rd_ptr_q];
  assign bus.inst_pc       = head_pc_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_pc_d  = head_pc_q;
    count_d    = count_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    if (redirect) begin
      // Everything still in flight becomes stale; a response landing now
      // retires one of those, whichever counter it was charged to.
      fetch_pc_d = redirect_pc_aligned;
      head_pc_d  = redirect_pc_aligned;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      outst_d    = '0;
      drop_d     = drop_q + outst_q - CW'(resp_ok);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + PC_STEP;
      end
      outst_d = outst_q + CW'(req_fire) - CW'(resp_ok && !resp_from_drop);
      drop_d  = drop_q - CW'(resp_from_drop);
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d  = rd_ptr_q + PW'(1);
        head_pc_d = head_pc_q + PC_STEP;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      head_pc_q  <= RESET_PC;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_pc_q  <= head_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else if (push) begin
      fifo_q[wr_ptr_q] <= bus.mem_resp_data;
    end
  end

  // A response with nothing in flight is a memory-side protocol violation.
  a_resp_expected: assert property (@(posedge clk) disable iff (rst)
    bus.mem_resp_valid |-> ((outst_q != '0) || (drop_q != '0)));

  a_credit_bound: assert property (@(posedge clk) disable iff (rst)
    (SW'(outst_q) + SW'(drop_q)) <= SW'(DEPTH));

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    push |-> ((count_q != CW'(DEPTH)) || pop));

endmodule
